// File: rtl/mips_pkg.sv
// mips_pkg: shared register-file and control-word constants for the pipeline registers
package mips_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W = 10;
  localparam int CTRL_ALU_OP_MSB = 9;
  localparam int CTRL_ALU_OP_LSB = 6;
  localparam int CTRL_ALU_SRC = 5;
  localparam int CTRL_REG_DST = 4;
  localparam int CTRL_REG_WRITE = 3;
  localparam int CTRL_MEM_READ = 2;
  localparam int CTRL_MEM_WRITE = 1;
  localparam int CTRL_MEM_TO_REG = 0;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/id_ex_bypass.sv
// id_ex_bypass: writeback compare-and-select for one operand (built only with ID_EX_FWD_EN)
`ifdef ID_EX_FWD_EN
module id_ex_bypass
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     data,
  output logic [DATA_W-1:0]     q
);
  assign q = (we && wb_addr != REG_ZERO && wb_addr == addr) ? wb_data : data;
endmodule
`endif

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with stall, flush bubbles and bubble counter
// ID_EX_FWD_EN enables writeback bypass into the captured and held operands.
module id_ex_pipe_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     rs_data,
  input  logic [DATA_W-1:0]     rt_data,
  input  logic [DATA_W-1:0]     imm,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [CTRL_W-1:0]     ctrl_in,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  out_valid,
  output logic [CTRL_W-1:0]     ctrl_out,
  output logic [DATA_W-1:0]     rs_q,
  output logic [DATA_W-1:0]     rt_q,
  output logic [DATA_W-1:0]     imm_q,
  output logic [REG_ADDR_W-1:0] rs_addr_q,
  output logic [REG_ADDR_W-1:0] rt_addr_q,
  output logic [REG_ADDR_W-1:0] rd_addr_q,
  output logic [CNT_W-1:0]      bubble_cnt
);
  logic [DATA_W-1:0] rs_nxt, rt_nxt;
`ifdef ID_EX_FWD_EN
  logic byp_we;
  // while stalled the bypass compares against the held specifiers, and only for a real instruction
  assign byp_we = wb_we & (!stall | out_valid);
  id_ex_bypass #(.DATA_W(DATA_W)) u_rs_byp (
    .we(byp_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .addr(stall ? rs_addr_q : rs_addr), .data(stall ? rs_q : rs_data), .q(rs_nxt)
  );
  id_ex_bypass #(.DATA_W(DATA_W)) u_rt_byp (
    .we(byp_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .addr(stall ? rt_addr_q : rt_addr), .data(stall ? rt_q : rt_data), .q(rt_nxt)
  );
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_addr, wb_data};
  assign rs_nxt = stall ? rs_q : rs_data;
  assign rt_nxt = stall ? rt_q : rt_data;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      ctrl_out <= '0;
      rs_q <= '0;
      rt_q <= '0;
      imm_q <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      bubble_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      ctrl_out <= '0;
      rs_q <= '0;
      rt_q <= '0;
      imm_q <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      bubble_cnt <= (&bubble_cnt) ? bubble_cnt : bubble_cnt + 1'b1;
    end else begin
      rs_q <= rs_nxt;
      rt_q <= rt_nxt;
      if (!stall) begin
        out_valid <= in_valid;
        ctrl_out <= ctrl_in;
        imm_q <= imm;
        rs_addr_q <= rs_addr;
        rt_addr_q <= rt_addr;
        rd_addr_q <= rd_addr;
      end
    end
  end
endmodule
